// File: rtl/matrix_pkg.sv
// Shared defaults, state encoding and index helper for the matrix inverse checker.
package matrix_pkg;

  localparam int N_DEF    = 3;
  localparam int W_DEF    = 16;
  localparam int FRAC_DEF = 8;
  localparam int TOL_DEF  = 2;
  localparam int ONE      = 1 << FRAC_DEF;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Row-major flat index of element (row, col) in an n x n matrix.
  function automatic int idx(input int row, input int col, input int n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/mat_mac_unit.sv
// Signed fixed-point multiply-accumulate; scaled shows (acc + a*b) >>> FRAC for the current step.
module mat_mac_unit #(
  parameter int W     = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 34
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    last,
  input  logic signed [W-1:0]     a,
  input  logic signed [W-1:0]     b,
  output logic signed [ACC_W-1:0] scaled
);

  logic signed [2*W-1:0]   prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;

  assign prod   = a * b;
  assign sum    = acc + {{(ACC_W-2*W){prod[2*W-1]}}, prod};
  assign scaled = sum >>> FRAC;

  // The final step of a dot product restarts the accumulator for the next element.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= last ? '0 : sum;
    end else begin
      acc <= acc;
    end
  end

endmodule

// File: rtl/matrix_inverse_checker.sv
// Checks A*B against identity within TOL LSBs. Optional MATRIX_CHECK_EARLY_ABORT_EN stops at the first mismatch.
module matrix_inverse_checker
  import matrix_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int TOL  = TOL_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sel,
  input  logic [W-1:0]         in_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [$clog2(N)-1:0] err_row,
  output logic [$clog2(N)-1:0] err_col,
  output logic [W-1:0]         err_val
);

  localparam int NN    = N * N;
  localparam int CW    = $clog2(NN + 1);
  localparam int AW    = $clog2(NN);
  localparam int IW    = $clog2(N);
  localparam int ACC_W = 2 * W + $clog2(N);
  localparam logic signed [ACC_W-1:0] ONE_V = {{(ACC_W-1){1'b0}}, 1'b1} << FRAC;
  localparam logic signed [ACC_W-1:0] TOL_V = ACC_W'(TOL);

  state_t                  state;
  logic [CW-1:0]           cnt_a;
  logic [CW-1:0]           cnt_b;
  logic signed [W-1:0]     a_mem [NN];
  logic signed [W-1:0]     b_mem [NN];
  logic [IW-1:0]           i;
  logic [IW-1:0]           j;
  logic [IW-1:0]           k;

  logic                    a_full;
  logic                    b_full;
  logic                    wr;
  logic                    start_ok;
  logic                    step;
  logic                    last_k;
  logic [AW-1:0]           a_addr;
  logic [AW-1:0]           b_addr;
  logic signed [ACC_W-1:0] c_val;
  logic signed [ACC_W-1:0] exp_val;
  logic signed [ACC_W-1:0] diff;
  logic signed [ACC_W-1:0] mag;
  logic                    mismatch;

  assign a_full   = (cnt_a == CW'(NN));
  assign b_full   = (cnt_b == CW'(NN));
  assign in_ready = (state == ST_LOAD) && (in_sel ? !b_full : !a_full);
  assign wr       = in_valid && in_ready && !clear;
  assign start_ok = (state == ST_LOAD) && start && a_full && b_full;
  assign step     = (state == ST_COMPUTE);
  assign last_k   = (k == IW'(N - 1));
  assign a_addr   = AW'(idx(int'(i), int'(k), N));
  assign b_addr   = AW'(idx(int'(k), int'(j), N));

  mat_mac_unit #(
    .W     (W),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_ok),
    .en     (step),
    .last   (last_k),
    .a      (a_mem[a_addr]),
    .b      (b_mem[b_addr]),
    .scaled (c_val)
  );

  assign exp_val  = (i == j) ? ONE_V : '0;
  assign diff     = c_val - exp_val;
  assign mag      = diff[ACC_W-1] ? -diff : diff;
  assign mismatch = step && last_k && (mag > TOL_V);

  // Element buffers carry no reset so their contents survive clear.
  always_ff @(posedge clk) begin
    if (wr && !in_sel) begin
      a_mem[AW'(cnt_a)] <= in_data;
    end
    if (wr && in_sel) begin
      b_mem[AW'(cnt_b)] <= in_data;
    end
  end

  // Control FSM, load counters, product indices and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_LOAD;
      cnt_a   <= '0;
      cnt_b   <= '0;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_row <= '0;
      err_col <= '0;
      err_val <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          done <= 1'b0;
          if (clear) begin
            cnt_a <= '0;
            cnt_b <= '0;
          end else if (wr) begin
            if (in_sel) cnt_b <= cnt_b + CW'(1);
            else        cnt_a <= cnt_a + CW'(1);
          end
          if (start_ok) begin
            pass    <= 1'b1;
            err_row <= '0;
            err_col <= '0;
            err_val <= '0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            busy    <= 1'b1;
            state   <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          if (last_k) begin
            k <= '0;
            // Error location is captured only while pass is still high, i.e. on the first mismatch.
            if (mismatch && pass) begin
              err_row <= i;
              err_col <= j;
              err_val <= c_val[W-1:0];
            end
            if (mismatch) pass <= 1'b0;
            if (j == IW'(N - 1)) begin
              j <= '0;
              if (i == IW'(N - 1)) begin
                i     <= '0;
                state <= ST_DONE;
              end else begin
                i <= i + IW'(1);
              end
            end else begin
              j <= j + IW'(1);
            end
`ifdef MATRIX_CHECK_EARLY_ABORT_EN
            if (mismatch) state <= ST_DONE;
`endif
          end else begin
            k <= k + IW'(1);
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_LOAD;
        end
        default: begin
          state <= ST_LOAD;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
